// File: rtl/store_rmw_controller_pkg.sv
// ---------------------------------------------------------------------------
// store_rmw_controller_pkg
//   Shared types and helpers for the store read-modify-write controller.
//   Contents:
//     state_t        - controller state encoding
//     MAX_ADDR_WIDTH - widest address the word_align helper handles
//     word_align()   - clears the byte-offset bits of an address
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package store_rmw_controller_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    RWAIT = 3'd2,
    WRITE = 3'd3,
    RESP  = 3'd4,
    ERR   = 3'd5
  } state_t;

  localparam int unsigned MAX_ADDR_WIDTH = 64;

  // Callers zero-extend into this width and truncate the result back.
  function automatic logic [MAX_ADDR_WIDTH-1:0] word_align(
    input logic [MAX_ADDR_WIDTH-1:0] addr
  );
    return {addr[MAX_ADDR_WIDTH-1:2], 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/store_memory_encoder.sv
// ---------------------------------------------------------------------------
// store_memory_encoder
//   Places right-aligned store data into its byte lanes and produces the
//   matching lane mask. Flags stores that would cross a word boundary.
//   Ports:
//     store_type [1:0]  in  STORE_B / STORE_H / STORE_W
//     addr_lo    [1:0]  in  byte offset within the word
//     wdata      [31:0] in  right-aligned store data
//     data       [31:0] out lane-shifted data (bits outside mask are junk)
//     mask       [31:0] out bit mask of the lanes written
//     exception         out store is misaligned for its width
//   Unknown store types produce a zero mask and no exception; the caller
//   decides how to treat them.
//   Revision: 1.0
// ---------------------------------------------------------------------------
`ifndef STORE_MEMORY_ENCODER_DEFS
`define STORE_MEMORY_ENCODER_DEFS
`define STORE_B 2'b00
`define STORE_H 2'b01
`define STORE_W 2'b10
`endif

`default_nettype none

module store_memory_encoder (
  input  logic [1:0]  store_type,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [31:0] data,
  output logic [31:0] mask,
  output logic        exception
);

  logic [4:0] shamt;

  assign shamt = {addr_lo, 3'b000};

  always_comb begin
    data      = wdata << shamt;
    mask      = 32'h0000_0000;
    exception = 1'b0;
    case (store_type)
      `STORE_B: begin
        mask = 32'h0000_00FF << shamt;
      end
      `STORE_H: begin
        // Any halfword that stays inside the word is legal (offsets 0..2).
        mask      = 32'h0000_FFFF << shamt;
        exception = (addr_lo == 2'd3);
      end
      `STORE_W: begin
        data      = wdata;
        mask      = 32'hFFFF_FFFF;
        exception = (addr_lo != 2'd0);
      end
      default: begin
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/store_rmw_controller.sv
// ---------------------------------------------------------------------------
// store_rmw_controller
//   Issues core stores onto a word-wide memory port without byte enables.
//   Full words are written directly; bytes and halfwords are read, merged
//   and written back. Misaligned or illegal stores get an error response
//   without touching memory. One store outstanding at a time.
//   Ports:
//     clk, rst_n                      clock, async active-low reset
//     req_valid/ready/type/addr/wdata store request from execute stage
//     resp_valid/ready/misaligned     completion / error response
//     mem_valid/ready/we/addr/wdata   memory request channel
//     mem_rvalid, mem_rdata           memory read return
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module store_rmw_controller
  import store_rmw_controller_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_type,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_misaligned,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_rvalid,
  input  logic [31:0]           mem_rdata
);

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           enc_data_q;
  logic [31:0]           mask_q;
  logic [31:0]           wdata_q;

  logic [31:0]           enc_data;
  logic [31:0]           enc_mask;
  logic                  enc_exception;
  logic                  type_legal;
  logic                  accept;

  store_memory_encoder u_encoder (
    .store_type (req_type),
    .addr_lo    (req_addr[1:0]),
    .wdata      (req_wdata),
    .data       (enc_data),
    .mask       (enc_mask),
    .exception  (enc_exception)
  );

  assign type_legal = (req_type == `STORE_B) || (req_type == `STORE_H) ||
                      (req_type == `STORE_W);
  assign accept     = req_valid && (state == IDLE);

  // Address and write data come straight from registers, so they cannot
  // move while a memory request is stalled.
  assign mem_addr  = ADDR_WIDTH'(word_align(MAX_ADDR_WIDTH'(addr_q)));
  assign mem_wdata = wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next      = state;
    req_ready       = 1'b0;
    resp_valid      = 1'b0;
    resp_misaligned = 1'b0;
    mem_valid       = 1'b0;
    mem_we          = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (enc_exception || !type_legal) begin
            state_next = ERR;
          end else if (req_type == `STORE_W) begin
            state_next = WRITE;
          end else begin
            state_next = READ;
          end
        end
      end
      READ: begin
        mem_valid = 1'b1;
        if (mem_ready) begin
          state_next = RWAIT;
        end
      end
      RWAIT: begin
        if (mem_rvalid) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        mem_valid = 1'b1;
        mem_we    = 1'b1;
        if (mem_ready) begin
          state_next = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_next = IDLE;
        end
      end
      ERR: begin
        resp_valid      = 1'b1;
        resp_misaligned = 1'b1;
        if (resp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      enc_data_q <= '0;
      mask_q     <= '0;
      wdata_q    <= '0;
    end else begin
      if (accept) begin
        addr_q     <= req_addr;
        enc_data_q <= enc_data;
        mask_q     <= enc_mask;
        // Full-word stores skip the read, so their data is final here.
        if (req_type == `STORE_W) begin
          wdata_q <= req_wdata;
        end
      end else if ((state == RWAIT) && mem_rvalid) begin
        // Mask keeps the encoder's junk bits out of the written word.
        wdata_q <= (mem_rdata & ~mask_q) | (enc_data_q & mask_q);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_store_rmw_controller.sv
// ---------------------------------------------------------------------------
// tb_store_rmw_controller
//   Self-checking bench: directed scenarios plus randomized stores, compared
//   against a byte-level memory model.
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_store_rmw_controller;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_type;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic          resp_misaligned;
  logic          mem_valid;
  logic          mem_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_rvalid;
  logic [31:0]   mem_rdata;

  always #5 clk = ~clk;

  store_rmw_controller #(.ADDR_WIDTH(AW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_type        (req_type),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_misaligned (resp_misaligned),
    .mem_valid       (mem_valid),
    .mem_ready       (mem_ready),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_rvalid      (mem_rvalid),
    .mem_rdata       (mem_rdata)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory image (word address -> word); unwritten words have a fixed pattern.
  logic [31:0] mem_img [logic [31:0]];

  function automatic logic [31:0] mem_read(input logic [31:0] wa);
    if (mem_img.exists(wa)) return mem_img[wa];
    return wa ^ 32'h5A5A_C3C3;
  endfunction

  // Responder configuration (written by the main process only).
  int rdy_pct     = 100;
  int rv_delay    = 1;
  int stall_cfg   = 0;
  int stray_want  = 0;

  // Responder state and logs (written by the responder only).
  int          cyc          = 0;
  int          n_rd         = 0;
  int          n_wr         = 0;
  int          n_valid_cyc  = 0;
  int          stray_given  = 0;
  int          rv_cnt       = 0;
  int          stall_left   = 0;
  logic [31:0] rv_addr      = '0;
  logic [31:0] rd_addr      = '0;
  logic [31:0] wr_addr      = '0;
  logic [31:0] wr_data      = '0;
  logic        prev_valid   = 1'b0;
  logic        prev_stall   = 1'b0;
  logic        p_we         = 1'b0;
  logic [31:0] p_addr       = '0;
  logic [31:0] p_data       = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: drives inputs on the falling edge; a handshake seen
  // here completes on the following rising edge.
  initial begin
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem_read(rv_addr);
        end
      end
      if (mem_valid) begin
        n_valid_cyc++;
        if (prev_stall) begin
          check_eq("mem_we_stable", 64'(mem_we), 64'(p_we));
          check_eq("mem_addr_stable", 64'(mem_addr), 64'(p_addr));
          check_eq("mem_wdata_stable", 64'(mem_wdata), 64'(p_data));
        end
        if (!prev_valid) stall_left = stall_cfg;
        if (stall_left > 0) begin
          mem_ready = 1'b0;
          stall_left--;
        end else begin
          mem_ready = (int'($urandom_range(1, 100)) <= rdy_pct);
        end
        if (mem_we && !mem_ready && !mem_rvalid && (stray_given < stray_want)) begin
          mem_rvalid = 1'b1;
          stray_given++;
        end
        if (mem_ready) begin
          if (mem_we) begin
            n_wr++;
            wr_addr = mem_addr;
            wr_data = mem_wdata;
            mem_img[mem_addr] = mem_wdata;
          end else begin
            n_rd++;
            rd_addr = mem_addr;
            rv_addr = mem_addr;
            rv_cnt  = rv_delay;
          end
        end
        prev_stall = !mem_ready;
        p_we       = mem_we;
        p_addr     = mem_addr;
        p_data     = mem_wdata;
      end else begin
        mem_ready  = 1'($urandom_range(0, 1));
        prev_stall = 1'b0;
      end
      prev_valid = mem_valid;
    end
  end

  // One store end to end; called and returns on a falling edge.
  task automatic do_store(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d,
                          input int resp_dly, input bit chk_lat);
    bit          err;
    bit          rr_bad;
    bit          stable_bad;
    int          off;
    int          nbytes;
    int          exp_rd;
    int          lat;
    int          rd0;
    int          wr0;
    int          v0;
    int          k;
    logic [31:0] wa;
    logic [31:0] exp_w;
    off    = int'(a[1:0]);
    wa     = {a[31:2], 2'b00};
    case (t)
      `STORE_B: nbytes = 1;
      `STORE_H: nbytes = 2;
      `STORE_W: nbytes = 4;
      default:  nbytes = 0;
    endcase
    err    = (nbytes == 0) || (off + nbytes > 4);
    exp_rd = (!err && nbytes < 4) ? 1 : 0;
    exp_w  = mem_read(wa);
    for (int i = 0; i < nbytes; i++) exp_w[8*(off+i) +: 8] = d[8*i +: 8];

    k = 0;
    while (!req_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check_eq("req_ready_idle", 64'(req_ready), 64'(1));

    rd0 = n_rd; wr0 = n_wr; v0 = n_valid_cyc;
    rr_bad = 1'b0; stable_bad = 1'b0;
    req_valid  = 1'b1;
    req_type   = t;
    req_addr   = a;
    req_wdata  = d;
    resp_ready = (resp_dly == 0);
    @(negedge clk);
    req_valid = 1'b0;
    req_type  = 2'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;

    lat = 1;
    while (lat < 300) begin
      rr_bad |= req_ready;
      if (resp_valid) break;
      @(negedge clk);
      lat++;
    end
    check_eq("resp_valid_seen", 64'(resp_valid), 64'(1));
    if (chk_lat) check_eq("latency", 64'(lat), 64'(err ? 1 : (exp_rd != 0 ? 4 : 2)));
    check_eq("resp_misaligned", 64'(resp_misaligned), 64'(err));
    for (int j = 0; j < resp_dly; j++) begin
      @(negedge clk);
      rr_bad |= req_ready;
      if (!resp_valid || (resp_misaligned !== err)) stable_bad = 1'b1;
    end
    resp_ready = 1'b1;
    @(negedge clk);
    check_eq("resp_taken", 64'(resp_valid), 64'(0));
    check_eq("req_ready_after", 64'(req_ready), 64'(1));
    check_eq("req_ready_low_busy", 64'(rr_bad), 64'(0));
    check_eq("resp_stable", 64'(stable_bad), 64'(0));
    check_eq("reads", 64'(n_rd - rd0), 64'(exp_rd));
    check_eq("writes", 64'(n_wr - wr0), 64'(err ? 0 : 1));
    if (err) begin
      check_eq("no_mem_valid", 64'(n_valid_cyc - v0), 64'(0));
    end else begin
      if (exp_rd != 0) check_eq("read_addr", 64'(rd_addr), 64'(wa));
      check_eq("write_addr", 64'(wr_addr), 64'(wa));
      check_eq("write_data", 64'(wr_data), 64'(exp_w));
    end
  endtask

  task automatic reset_test();
    int rd0;
    int wr0;
    int k;
    bit saw_resp;
    rdy_pct = 100; rv_delay = 20; stall_cfg = 0;
    rd0 = n_rd; wr0 = n_wr;
    req_valid = 1'b1; req_type = `STORE_B; req_addr = 32'h0000_0341; req_wdata = 32'h0000_0077;
    resp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    k = 0;
    while (n_rd == rd0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check_eq("rst_read_issued", 64'(n_rd - rd0), 64'(1));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_req_ready", 64'(req_ready), 64'(1));
    check_eq("rst_mem_valid", 64'(mem_valid), 64'(0));
    check_eq("rst_mem_we", 64'(mem_we), 64'(0));
    check_eq("rst_mem_addr", 64'(mem_addr), 64'(0));
    check_eq("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    check_eq("rst_resp_valid", 64'(resp_valid), 64'(0));
    check_eq("rst_resp_mis", 64'(resp_misaligned), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_release_ready", 64'(req_ready), 64'(1));
    saw_resp = 1'b0;
    for (int j = 0; j < 25; j++) begin
      @(negedge clk);
      saw_resp |= resp_valid | mem_valid;
    end
    check_eq("rst_late_rvalid_no_write", 64'(n_wr - wr0), 64'(0));
    check_eq("rst_no_activity", 64'(saw_resp), 64'(0));
    rv_delay = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  t;
    logic [31:0] a;
    int          rd;
    req_valid  = 1'b0;
    req_type   = '0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b1;
    @(negedge clk);
    check_eq("reset_req_ready", 64'(req_ready), 64'(1));
    check_eq("reset_mem_valid", 64'(mem_valid), 64'(0));
    check_eq("reset_resp_valid", 64'(resp_valid), 64'(0));
    check_eq("reset_mem_wdata", 64'(mem_wdata), 64'(0));
    check_eq("reset_mem_addr", 64'(mem_addr), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Full word, byte merge, halfword merge.
    do_store(`STORE_W, 32'h0000_0100, 32'hDEAD_BEEF, 0, 1'b1);
    check_eq("tp1_word", 64'(wr_data), 64'(32'hDEAD_BEEF));
    do_store(`STORE_W, 32'h0000_0100, 32'h1122_3344, 0, 1'b1);
    do_store(`STORE_B, 32'h0000_0103, 32'h0000_00AA, 0, 1'b1);
    check_eq("tp2_merge", 64'(wr_data), 64'(32'hAA22_3344));
    do_store(`STORE_W, 32'h0000_0200, 32'hFFFF_FFFF, 0, 1'b1);
    do_store(`STORE_H, 32'h0000_0201, 32'h0000_BEEF, 0, 1'b1);
    check_eq("tp3_merge", 64'(wr_data), 64'(32'hFFBE_EFFF));

    // Misaligned and illegal.
    do_store(`STORE_H, 32'h0000_0303, 32'h1234_5678, 0, 1'b1);
    do_store(`STORE_W, 32'h0000_0302, 32'h1234_5678, 0, 1'b1);
    do_store(2'b11,    32'h0000_0300, 32'h1234_5678, 0, 1'b1);

    // Backpressure everywhere plus a stray read return during the write.
    stall_cfg = 5; rv_delay = 7; stray_want = stray_want + 1;
    do_store(`STORE_H, 32'h0000_0402, 32'hCAFE_F00D, 3, 1'b0);
    check_eq("stray_delivered", 64'(stray_given), 64'(stray_want));
    do_store(`STORE_W, 32'h0000_0404, 32'h0BAD_F00D, 3, 1'b0);
    stall_cfg = 0; rv_delay = 1;

    reset_test();
    do_store(`STORE_B, 32'h0000_0342, 32'h0000_0055, 0, 1'b1);

    // Randomized stores over a small pool of words so merges overlap.
    for (int n = 0; n < 40; n++) begin
      t  = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 9) == 0) ? $urandom
                                       : 32'h0000_1000 + 32'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
      rd = $urandom_range(0, 2);
      rdy_pct  = ($urandom_range(0, 1) == 1) ? 100 : int'($urandom_range(30, 90));
      rv_delay = int'($urandom_range(1, 4));
      if ($urandom_range(0, 3) == 0) stray_want = stray_want + 1;
      do_store(t, a, $urandom, rd, (rdy_pct == 100) && (rv_delay == 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/store_rmw_controller.md
Name: store_rmw_controller

Overview:
Sequences a store from the core's execute stage onto a word-wide memory port that has no byte enables. Full-word stores issue as a single write. Byte and halfword stores issue as read-modify-write: read the old word, merge the new bytes through the store_memory_encoder data/mask, then write back. Misaligned or illegal stores never touch memory and return an error response. The block sits between the execute stage and the data memory / bus adapter.

Parameters:
ADDR_WIDTH, 32, byte address width on both the request and memory sides (minimum 3).

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst_n  input  1  asynchronous, active-low reset
req_valid  input  1  store request valid
req_ready  output  1  controller can accept a request
req_type  input  2  store width, encoded with the STORE_B / STORE_H / STORE_W defines
req_addr  input  ADDR_WIDTH  byte address
req_wdata  input  32  store data, right-aligned
resp_valid  output  1  store complete or rejected
resp_ready  input  1  consumer accepts the response
resp_misaligned  output  1  response carries an error (misaligned or illegal type); valid while resp_valid
mem_valid  output  1  memory request valid
mem_ready  input  1  memory accepts the request
mem_we  output  1  1 = write, 0 = read
mem_addr  output  ADDR_WIDTH  word address, low 2 bits always 0
mem_wdata  output  32  write data
mem_rvalid  input  1  read data valid; one pulse per read
mem_rdata  input  32  read data

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state IDLE; req_ready=1, resp_valid=0, resp_misaligned=0, mem_valid=0, mem_we=0, mem_addr=0, mem_wdata=0; all latched request registers cleared.
- Reset asserted mid-operation forces IDLE immediately. Any in-flight memory transaction is abandoned, and a later mem_rvalid for it is ignored.
- States:
  - IDLE: req_ready=1. On req_valid&&req_ready, latch type, addr, wdata, and the encoder outputs (data, mask, exception) computed from req_type, req_addr[1:0] and req_wdata. Then:
    - encoder exception, or type not one of the three defines -> ERR.
    - STORE_W -> WRITE.
    - otherwise -> READ.
  - READ: mem_valid=1, mem_we=0, mem_addr={addr[AW-1:2],2'b00}. On mem_ready -> RWAIT.
  - RWAIT: mem_valid=0. On mem_rvalid, compute merged=(mem_rdata & ~mask) | (enc_data & mask), register it into mem_wdata, -> WRITE. mem_rvalid in any other state is ignored.
  - WRITE: mem_valid=1, mem_we=1, same mem_addr. mem_wdata is the merged word, or req_wdata for STORE_W. On mem_ready -> RESP. Writes are posted: no write acknowledge.
  - RESP / ERR: resp_valid=1; resp_misaligned=0 in RESP, 1 in ERR. On resp_ready -> IDLE.
- req_ready is 1 only in IDLE. No back-to-back overlap; one store is outstanding at a time.
- While mem_valid=1 && mem_ready=0, mem_we, mem_addr and mem_wdata are held stable. The same rule applies to resp_misaligned while resp_valid=1 && resp_ready=0.
- The encoder's don't-care data bits must never reach mem_wdata. The mask guarantees this for sub-word stores; for STORE_W the mask is all ones.
- Latency with mem_ready=1, mem_rvalid one cycle after the read handshake, resp_ready=1:
  - STORE_W: accept cycle 0, write cycle 1, resp_valid cycle 2.
  - Sub-word: accept 0, read 1, rvalid 2, write 3, resp_valid 4.
  - Error: accept 0, resp_valid 1; mem_valid never asserted.
- The address is taken mod 2^ADDR_WIDTH; there is no wrap logic beyond truncation.

Decomposition:
- The STORE_B/H/W codes stay in the existing store_memory_encoder header.
- A small shared package holds the state enum (IDLE, READ, RWAIT, WRITE, RESP, ERR) and the word-align helper.
- One sub-module: an instance of store_memory_encoder, driven combinationally from the request in IDLE; its outputs are latched on accept.

Test Plan:
1. Full-word store: STORE_W, addr=0x100, data=0xDEADBEEF -> exactly one write, mem_addr=0x100, mem_wdata=0xDEADBEEF; no read; resp_misaligned=0 two cycles after accept.
2. Byte merge: STORE_B, addr=0x103, data=0x000000AA; memory returns 0x11223344 -> read then write of 0xAA223344 to 0x100.
3. Halfword merge: STORE_H, addr=0x201, data=0x0000BEEF; memory returns 0xFFFFFFFF -> write 0xFFBEEFFF to 0x200.
4. Misaligned store: STORE_H at offset 3, then STORE_W at offset 2 -> each produces resp_valid with resp_misaligned=1 one cycle after accept; mem_valid stays 0 throughout.
5. Backpressure: mem_ready held 0 for 5 cycles in READ and in WRITE, mem_rvalid delayed 7 cycles, resp_ready delayed 3 cycles -> mem_* and response fields stable; req_ready=0 until the response is taken; a stray mem_rvalid in WRITE is ignored.
6. Async reset: deassert rst_n in RWAIT, release it, then send a late mem_rvalid -> all outputs take reset values immediately, no write is issued, and req_ready=1 on the first cycle after release.
